// File: rtl/int_alu_sequencer.sv
// rtl/int_alu_sequencer.sv - request/response sequencer for the integer ALU register file
// Optional macro INT_ALU_SEQ_DIVZERO_CHK_EN rejects DIV requests whose divisor (ReqSrc1) is zero.
module int_alu_sequencer #(
  parameter logic [3:0] INT_ALU_EN = 4'h1,
  parameter int         POLL_LIMIT = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic [7:0]   ReqOp,
  input  logic [255:0] ReqSrc1,
  input  logic [255:0] ReqSrc2,
  output logic         RspValid,
  input  logic         RspReady,
  output logic [255:0] RspData,
  output logic         RspError,
  output logic [15:0]  address,
  output logic         nWrite,
  output logic         nRead,
  output logic [255:0] ExeDataOut,
  input  logic [255:0] IntDataOut
);

  localparam int CW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, WR_SRC1, WR_SRC2, WR_OP, POLL, RD_RES, RESP} state_t;

  state_t         state, state_nxt;
  logic [7:0]     op_q;
  logic [255:0]   src1_q, src2_q;
  logic [CW-1:0]  poll_cnt;
  logic [255:0]   rsp_data_q;
  logic           rsp_err_q;
  logic           div_zero, op_ok, done, poll_last;

`ifdef INT_ALU_SEQ_DIVZERO_CHK_EN
  assign div_zero = (ReqOp == 8'h13) && (ReqSrc1 == '0);
`else
  assign div_zero = 1'b0;
`endif

  assign op_ok     = (ReqOp >= 8'h10) && (ReqOp <= 8'h13) && !div_zero;
  assign done      = IntDataOut[0];
  assign poll_last = (poll_cnt == CW'(POLL_LIMIT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ReqValid) state_nxt = op_ok ? WR_SRC1 : RESP;
      WR_SRC1: state_nxt = WR_SRC2;
      WR_SRC2: state_nxt = WR_OP;
      WR_OP:   state_nxt = POLL;
      POLL: begin
        if (done)           state_nxt = RD_RES;
        else if (poll_last) state_nxt = RESP;
      end
      RD_RES:  state_nxt = RESP;
      RESP:    if (RspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus strobes and address are pure state decodes, so they never glitch on handshake inputs.
  always_comb begin
    address    = 16'h0;
    nWrite     = 1'b1;
    nRead      = 1'b1;
    ExeDataOut = '0;
    case (state)
      WR_SRC1: begin address = {INT_ALU_EN, 12'd0}; nWrite = 1'b0; ExeDataOut = src1_q; end
      WR_SRC2: begin address = {INT_ALU_EN, 12'd1}; nWrite = 1'b0; ExeDataOut = src2_q; end
      WR_OP:   begin address = {INT_ALU_EN, 12'd3}; nWrite = 1'b0; ExeDataOut = {248'b0, op_q}; end
      POLL:    begin address = {INT_ALU_EN, 12'd4}; nRead = 1'b0; end
      RD_RES:  begin address = {INT_ALU_EN, 12'd2}; nRead = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      op_q       <= 8'h0;
      src1_q     <= '0;
      src2_q     <= '0;
      poll_cnt   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            op_q       <= ReqOp;
            src1_q     <= ReqSrc1;
            src2_q     <= ReqSrc2;
            poll_cnt   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= !op_ok;
          end
        end
        POLL: begin
          if (!done) begin
            poll_cnt <= poll_cnt + CW'(1);
            if (poll_last) begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        RD_RES: begin
          rsp_data_q <= IntDataOut;
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ReqReady = (state == IDLE);
  assign RspValid = (state == RESP);
  assign RspData  = rsp_data_q;
  assign RspError = rsp_err_q;

endmodule

// File: tb/tb_int_alu_sequencer.sv
// tb/tb_int_alu_sequencer.sv - randomized self-checking bench with ALU stub and cycle model
module tb_int_alu_sequencer;
  localparam int PL = 16;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         ReqValid = 1'b0;
  logic         ReqReady;
  logic [7:0]   ReqOp = 8'h0;
  logic [255:0] ReqSrc1 = '0;
  logic [255:0] ReqSrc2 = '0;
  logic         RspValid;
  logic         RspReady = 1'b0;
  logic [255:0] RspData;
  logic         RspError;
  logic [15:0]  address;
  logic         nWrite;
  logic         nRead;
  logic [255:0] ExeDataOut;
  logic [255:0] IntDataOut;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 0;

  always #5 Clk = ~Clk;

  int_alu_sequencer #(.INT_ALU_EN(4'h1), .POLL_LIMIT(PL)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqSrc1(ReqSrc1), .ReqSrc2(ReqSrc2), .RspValid(RspValid), .RspReady(RspReady),
    .RspData(RspData), .RspError(RspError), .address(address), .nWrite(nWrite),
    .nRead(nRead), .ExeDataOut(ExeDataOut), .IntDataOut(IntDataOut)
  );

  task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ALU semantics: 256-bit modulo arithmetic, DIV is b/a, divide by zero returns all ones.
  function automatic logic [255:0] alu_fn(input logic [7:0] op, input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    case (op)
      8'h10: r = a + b;
      8'h11: r = a - b;
      8'h12: r = a * b;
      8'h13: r = (a == '0) ? '1 : b / a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // ALU stub: status done once cur_lat not-done polls have been seen since the trigger write.
  logic [255:0] alu_reg [0:4];
  int polls_seen = 0;
  int cur_lat = 0;
  int stub_lat = 0;

  always @(posedge Clk) begin
    if (!nWrite && address[15:12] == 4'h1 && address[11:0] < 12'd5) begin
      alu_reg[address[2:0]] <= ExeDataOut;
      if (address[11:0] == 12'd3) polls_seen <= 0;
    end
    if (!nRead && address == 16'h1004) polls_seen <= polls_seen + 1;
  end

  always_comb begin
    IntDataOut = '0;
    if (!nRead) begin
      if (address == 16'h1004) IntDataOut = {255'b0, (polls_seen >= cur_lat)};
      else if (address == 16'h1002) IntDataOut = alu_fn(alu_reg[3][7:0], alu_reg[0], alu_reg[1]);
    end
  end

  int poll_mon = 0;
  int bus_mon = 0;
  always @(posedge Clk) begin
    if (!nRead && address == 16'h1004) poll_mon <= poll_mon + 1;
    if (!nRead || !nWrite) bus_mon <= bus_mon + 1;
  end

  // Reference model: on acceptance, the full per-cycle bus script and the final response.
  typedef struct {
    logic         nw;
    logic         nr;
    logic [15:0]  addr;
    logic [255:0] data;
  } cyc_t;
  typedef enum {M_IDLE, M_BUSY, M_RESP} mph_t;

  cyc_t         exp_q[$];
  mph_t         ph = M_IDLE;
  logic [255:0] exp_data = '0;
  logic         exp_err = 1'b0;

  function automatic void push(input logic nw, input logic nr, input logic [3:0] off, input logic [255:0] d);
    cyc_t c;
    c.nw = nw; c.nr = nr; c.addr = {4'h1, 8'h0, off}; c.data = d;
    exp_q.push_back(c);
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      ph = M_IDLE;
      exp_q.delete();
    end else begin
      case (ph)
        M_IDLE: if (ReqValid) begin
          bit ok;
          ok = (ReqOp >= 8'h10 && ReqOp <= 8'h13);
`ifdef INT_ALU_SEQ_DIVZERO_CHK_EN
          if (ReqOp == 8'h13 && ReqSrc1 == '0) ok = 0;
`endif
          cur_lat = stub_lat;
          if (!ok) begin
            exp_data = '0; exp_err = 1'b1; ph = M_RESP;
          end else begin
            push(0, 1, 4'd0, ReqSrc1);
            push(0, 1, 4'd1, ReqSrc2);
            push(0, 1, 4'd3, {248'b0, ReqOp});
            if (stub_lat >= PL) begin
              for (int i = 0; i < PL; i++) push(1, 0, 4'd4, '0);
              exp_data = '0; exp_err = 1'b1;
            end else begin
              for (int i = 0; i <= stub_lat; i++) push(1, 0, 4'd4, '0);
              push(1, 0, 4'd2, '0);
              exp_data = alu_fn(ReqOp, ReqSrc1, ReqSrc2); exp_err = 1'b0;
            end
            ph = M_BUSY;
          end
        end
        M_BUSY: begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) ph = M_RESP;
        end
        M_RESP: if (RspReady) ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      case (ph)
        M_BUSY: begin
          chk("busy ctrl {rdy,vld,nw,nr,addr}", {ReqReady, RspValid, nWrite, nRead, address},
              {1'b0, 1'b0, exp_q[0].nw, exp_q[0].nr, exp_q[0].addr});
          chk("busy wdata", ExeDataOut, exp_q[0].data);
        end
        M_RESP: begin
          chk("resp ctrl {rdy,vld,nw,nr,addr}", {ReqReady, RspValid, nWrite, nRead, address},
              {1'b0, 1'b1, 1'b1, 1'b1, 16'h0});
          chk("resp {err,data}", {RspError, RspData}, {exp_err, exp_data});
        end
        default: begin
          chk("idle ctrl {rdy,vld,nw,nr,addr}", {ReqReady, RspValid, nWrite, nRead, address},
              {1'b1, 1'b0, 1'b1, 1'b1, 16'h0});
          chk("idle wdata", ExeDataOut, '0);
        end
      endcase
    end
  end

  task automatic run_dir(input string nm, input logic [7:0] op, input logic [255:0] a,
                         input logic [255:0] b, input int lat, input logic [255:0] ed,
                         input logic ee, input int elat, input int epolls, input int ebus);
    int cyc;
    @(negedge Clk);
    stub_lat = lat; ReqOp = op; ReqSrc1 = a; ReqSrc2 = b; ReqValid = 1'b1; RspReady = 1'b0;
    poll_mon = 0; bus_mon = 0;
    @(negedge Clk);
    ReqValid = 1'b0;
    cyc = 1;
    while (!RspValid && cyc < 200) begin
      @(negedge Clk);
      cyc++;
    end
    chk({nm, " latency"}, cyc, elat);
    chk({nm, " data"}, RspData, ed);
    chk({nm, " error"}, RspError, ee);
    if (epolls >= 0) chk({nm, " polls"}, poll_mon, epolls);
    if (ebus >= 0) chk({nm, " bus cycles"}, bus_mon, ebus);
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    chk({nm, " idle after rsp"}, {ReqReady, RspValid}, 2'b10);
  endtask

  initial begin
    logic [255:0] big;
    int cyc;
    big = '0; big[255] = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset outputs", {ReqReady, RspValid, RspError, nWrite, nRead, address},
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0});
    chk("reset data", {RspData, ExeDataOut} , '0);
    chk_en = 1;
    Reset = 1'b0;

    run_dir("add",     8'h10, 256'd5, 256'd7,   0, 256'd12, 1'b0, 6, 1, 5);
    run_dir("sub",     8'h11, 256'd0, 256'd1,   0, '1,      1'b0, 6, 1, 5);
    run_dir("mult",    8'h12, big,    256'd2,   0, '0,      1'b0, 6, 1, 5);
    run_dir("div",     8'h13, 256'd4, 256'd100, 0, 256'd25, 1'b0, 6, 1, 5);
    run_dir("slow",    8'h10, 256'd1, 256'd2,   3, 256'd3,  1'b0, 9, 4, 8);
    run_dir("invalid", 8'h20, 256'd4, 256'd100, 0, '0,      1'b1, 1, 0, 0);
    run_dir("timeout", 8'h10, 256'd5, 256'd7,   PL + 5, '0, 1'b1, PL + 4, PL, PL + 3);
    run_dir("edge lat", 8'h10, 256'd5, 256'd7,  PL - 1, 256'd12, 1'b0, PL + 5, PL, PL + 4);
`ifdef INT_ALU_SEQ_DIVZERO_CHK_EN
    run_dir("div0",    8'h13, 256'd0, 256'd9,   0, '0,      1'b1, 1, 0, 0);
`else
    run_dir("div0",    8'h13, 256'd0, 256'd9,   0, '1,      1'b0, 6, 1, 5);
`endif

    // Backpressure with request noise.
    @(negedge Clk);
    stub_lat = 2; ReqOp = 8'h10; ReqSrc1 = 256'd5; ReqSrc2 = 256'd7; ReqValid = 1'b1;
    @(negedge Clk);
    ReqValid = 1'b0;
    cyc = 1;
    while (!RspValid && cyc < 200) begin @(negedge Clk); cyc++; end
    for (int i = 0; i < 10; i++) begin
      ReqValid = i[0];
      ReqOp = 8'h11;
      chk("bp hold", {ReqReady, RspValid, RspError, RspData}, {1'b0, 1'b1, 1'b0, 256'd12});
      @(negedge Clk);
    end
    ReqValid = 1'b0; RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    chk("bp release", {ReqReady, RspValid}, 2'b10);

    // Reset during WR_SRC2.
    ReqOp = 8'h10; ReqValid = 1'b1; stub_lat = 0;
    @(negedge Clk);
    ReqValid = 1'b0;
    @(negedge Clk);
    chk("wr_src2 addr", {nWrite, address}, {1'b0, 16'h1001});
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid reset", {ReqReady, RspValid, RspError, nWrite, nRead, address}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0});
    chk("mid reset data", {RspData, ExeDataOut}, '0);
    repeat (3) @(negedge Clk);
    chk("no rsp after reset", RspValid, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      int r;
      @(negedge Clk);
      r = $urandom_range(0, 9);
      ReqValid = ($urandom_range(0, 2) == 0);
      ReqOp = (r < 8) ? 8'h10 + 8'(r % 4) : ((r == 8) ? 8'($urandom) : 8'h13);
      ReqSrc1 = ($urandom_range(0, 1) == 0) ? {8{$urandom}} : 256'($urandom_range(0, 9));
      ReqSrc2 = {8{$urandom}};
      if (r == 9) ReqSrc1 = '0;
      r = $urandom_range(0, 9);
      stub_lat = (r == 0) ? PL + $urandom_range(0, 2) : ((r == 1) ? PL - 1 : $urandom_range(0, 3));
      RspReady = $urandom_range(0, 1);
      Reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge Clk);
    Reset = 1'b0; ReqValid = 1'b0; RspReady = 1'b1;
    cyc = 0;
    while (ph != M_IDLE && cyc < 100) begin @(negedge Clk); cyc++; end
    chk("drain", (ph == M_IDLE), 1'b1);
    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
